// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - synthetic OV7670 VSYNC/HREF/D source with selectable test patterns
module ov7670_stream_gen #(
  parameter int IMG_W         = 640,
  parameter int IMG_H         = 480,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done
);

  localparam int T_LINE  = 2 * IMG_W + H_BLANK;
  localparam int VS_CLKS = VSYNC_LINES * T_LINE;
  localparam int VB_CLKS = V_BACK_LINES * T_LINE;
  localparam int VF_CLKS = V_FRONT_LINES * T_LINE;
  localparam int M1      = (VS_CLKS > VB_CLKS) ? VS_CLKS : VB_CLKS;
  localparam int M2      = (M1 > VF_CLKS) ? M1 : VF_CLKS;
  localparam int CNT_MAX = (M2 > H_BLANK) ? M2 : H_BLANK;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BAR_W   = IMG_W / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [CW-1:0] VS_LAST = CW'(VS_CLKS - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VB_CLKS - 1);
  localparam logic [CW-1:0] VF_LAST = CW'(VF_CLKS - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [BW-1:0] BP_LAST = BW'(BAR_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [XW-1:0] x, x_n;
  logic          phase, phase_n;      // 0 = byte0 {0,R}, 1 = byte1 {G,B}
  logic [YW-1:0] y, y_n;
  logic [2:0]    bar_idx, bar_idx_n;
  logic [BW-1:0] bar_px, bar_px_n;
  logic [1:0]    pat_q;
  logic [11:0]   rgb_q;
  logic          start_frame, emit;
  logic          vsync_n, busy_n, frame_done_n;
  logic [7:0]    d_n;
  logic [11:0]   col;
  logic [5:0]    x6, y6;

  // Next-state and next-output logic; counters describe the byte that will be on d next cycle
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    x_n         = x;
    phase_n     = phase;
    y_n         = y;
    bar_idx_n   = bar_idx;
    bar_px_n    = bar_px;
    vsync_n     = 1'b0;
    busy_n      = busy;
    start_frame = 1'b0;
    emit        = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (enable) start_frame = 1'b1;
      end
      S_VSYNC: begin
        if (cnt == VS_LAST) begin
          state_n = S_VBACK;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CW'(1);
          vsync_n = 1'b1;
        end
      end
      S_VBACK: begin
        if (cnt == VB_LAST) begin
          state_n   = S_ACTIVE;
          cnt_n     = '0;
          x_n       = '0;
          phase_n   = 1'b0;
          y_n       = '0;
          bar_idx_n = '0;
          bar_px_n  = '0;
          emit      = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (x == X_LAST && phase) begin
          state_n = S_HBLANK;
          cnt_n   = '0;
        end else begin
          emit    = 1'b1;
          phase_n = ~phase;
          if (phase) begin
            x_n = x + XW'(1);
            if (bar_px == BP_LAST) begin
              bar_idx_n = bar_idx + 3'd1;
              bar_px_n  = '0;
            end else begin
              bar_px_n  = bar_px + BW'(1);
            end
          end
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_n = '0;
          if (y == Y_LAST) begin
            state_n = S_VFRONT;
          end else begin
            state_n   = S_ACTIVE;
            y_n       = y + YW'(1);
            x_n       = '0;
            phase_n   = 1'b0;
            bar_idx_n = '0;
            bar_px_n  = '0;
            emit      = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_VFRONT: begin
        if (cnt == VF_LAST) begin
          cnt_n = '0;
          if (enable) begin
            start_frame = 1'b1;
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (start_frame) begin
      state_n = S_VSYNC;
      cnt_n   = '0;
      y_n     = '0;
      vsync_n = 1'b1;
      busy_n  = 1'b1;
    end
    frame_done_n = (state_n == S_VFRONT) && (cnt_n == VF_LAST);
  end

  // Pattern colour of the next pixel and the byte of it that goes out next
  always_comb begin
    x6 = 6'(x_n);
    y6 = 6'(y_n);
    col = 12'h000;
    case (pat_q)
      2'd0: begin
        case (bar_idx_n)
          3'd0:    col = 12'hFFF;
          3'd1:    col = 12'hFF0;
          3'd2:    col = 12'h0FF;
          3'd3:    col = 12'h0F0;
          3'd4:    col = 12'hF0F;
          3'd5:    col = 12'hF00;
          3'd6:    col = 12'h00F;
          default: col = 12'h000;
        endcase
      end
      2'd1:    col = {x6[3:0], x6[3:0], x6[3:0]};
      2'd2:    col = (|((x6 ^ y6) & 6'h20)) ? 12'hFFF : 12'h000;
      default: col = rgb_q;
    endcase
    d_n = 8'h00;
    if (emit) d_n = phase_n ? col[7:0] : {4'h0, col[11:8]};
  end

  // State, counters, latched pattern and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      phase      <= 1'b0;
      y          <= '0;
      bar_idx    <= '0;
      bar_px     <= '0;
      pat_q      <= '0;
      rgb_q      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      x          <= x_n;
      phase      <= phase_n;
      y          <= y_n;
      bar_idx    <= bar_idx_n;
      bar_px     <= bar_px_n;
      vsync      <= vsync_n;
      href       <= emit;
      d          <= d_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      if (start_frame) begin
        pat_q <= pattern;
        rgb_q <= solid_rgb;
      end
    end
  end

endmodule
